// File: rtl/jtag_dma_cmd_engine.sv
// rtl/jtag_dma_cmd_engine.sv - JTAG-driven DMA command engine with write/read data FIFOs
module jtag_dma_cmd_engine #(
  parameter int DATA_WIDTH  = 32,
  parameter int BUF_DEPTH   = 16,
  parameter int BURST_WIDTH = 8
) (
  input  logic                      system_clk,
  input  logic                      system_reset,
  input  logic                      cmd_valid,
  output logic                      cmd_ready,
  input  logic [3:0]                cmd_opcode,
  input  logic [DATA_WIDTH-1:0]     cmd_data,
  output logic                      resp_valid,
  output logic [DATA_WIDTH-1:0]     resp_data,
  output logic                      dma_start,
  output logic                      dma_rnw,
  output logic [31:0]               dma_address,
  output logic [DATA_WIDTH/8-1:0]   dma_byte_enable,
  output logic [BURST_WIDTH-1:0]    dma_burst_size,
  input  logic                      dma_busy,
  input  logic                      dma_wr_pop,
  output logic [DATA_WIDTH-1:0]     dma_wr_data,
  input  logic                      dma_rd_push,
  input  logic [DATA_WIDTH-1:0]     dma_rd_data
);

  localparam int AW  = $clog2(BUF_DEPTH);
  localparam int CW  = AW + 1;
  localparam int BEW = DATA_WIDTH / 8;
  localparam int SW  = 3 + 2 * CW + 2;

  localparam logic [1:0] S_IDLE      = 2'd0;
  localparam logic [1:0] S_ISSUE     = 2'd1;
  localparam logic [1:0] S_WAIT_BUSY = 2'd2;
  localparam logic [1:0] S_WAIT_DONE = 2'd3;

  logic [1:0]             state;
  logic [2:0]             errors;
  logic [31:0]            address_q;
  logic [BEW-1:0]         byte_en_q;
  logic [BURST_WIDTH-1:0] burst_q;

  logic [DATA_WIDTH-1:0] wr_mem [BUF_DEPTH];
  logic [AW-1:0]         wr_wptr, wr_rptr;
  logic [CW-1:0]         wr_count;
  logic [DATA_WIDTH-1:0] rd_mem [BUF_DEPTH];
  logic [AW-1:0]         rd_wptr, rd_rptr;
  logic [CW-1:0]         rd_count;

  logic accept;
  logic wr_full, wr_empty, wr_push_req, wr_push_ok, wr_pop_ok, wr_overflow;
  logic rd_full, rd_empty, rd_pop_req, rd_push_ok, rd_pop_ok, rd_overflow, rd_underflow;
  logic launch_req, launch_bad;
  logic [DATA_WIDTH-1:0] rd_pop_data;
  logic [SW-1:0]         status_word;
  logic                  resp_hit;
  logic [DATA_WIDTH-1:0] resp_next;

  assign cmd_ready       = (state == S_IDLE);
  assign accept          = cmd_valid && cmd_ready;
  assign dma_start       = (state == S_ISSUE);
  assign dma_address     = address_q;
  assign dma_byte_enable = byte_en_q;
  assign dma_burst_size  = burst_q;

  // A simultaneous push and pop always both succeed; on an empty FIFO the word passes straight through.
  assign wr_full     = (wr_count == CW'(BUF_DEPTH));
  assign wr_empty    = (wr_count == '0);
  assign wr_push_req = accept && (cmd_opcode == 4'h8);
  assign wr_pop_ok   = dma_wr_pop && (!wr_empty || wr_push_req);
  assign wr_push_ok  = wr_push_req && (!wr_full || dma_wr_pop);
  assign wr_overflow = wr_push_req && !wr_push_ok;
  assign dma_wr_data = wr_empty ? cmd_data : wr_mem[wr_rptr];

  assign rd_full      = (rd_count == CW'(BUF_DEPTH));
  assign rd_empty     = (rd_count == '0);
  assign rd_pop_req   = accept && (cmd_opcode == 4'h9);
  assign rd_pop_ok    = rd_pop_req && (!rd_empty || dma_rd_push);
  assign rd_push_ok   = dma_rd_push && (!rd_full || rd_pop_req);
  assign rd_overflow  = dma_rd_push && !rd_push_ok;
  assign rd_underflow = rd_pop_req && !rd_pop_ok;
  assign rd_pop_data  = rd_empty ? dma_rd_data : rd_mem[rd_rptr];

  // A write launch needs burst_size+1 words queued, i.e. count > burst_size.
  assign launch_req = accept && ((cmd_opcode == 4'hA) || (cmd_opcode == 4'hC));
  assign launch_bad = dma_busy ||
                      ((cmd_opcode == 4'hA) && (32'(wr_count) <= 32'(burst_q)));

  assign status_word = {errors, wr_count, rd_count, state};

  always_comb begin
    resp_hit  = 1'b0;
    resp_next = '0;
    if (accept) begin
      case (cmd_opcode)
        4'h0: begin resp_hit = 1'b1; resp_next = DATA_WIDTH'(status_word); end
        4'h4: begin resp_hit = 1'b1; resp_next = DATA_WIDTH'(address_q);   end
        4'h5: begin resp_hit = 1'b1; resp_next = DATA_WIDTH'(byte_en_q);   end
        4'h6: begin resp_hit = 1'b1; resp_next = DATA_WIDTH'(burst_q);     end
        4'h9: begin resp_hit = 1'b1; resp_next = rd_pop_ok ? rd_pop_data : '0; end
        default: begin resp_hit = 1'b0; resp_next = '0; end
      endcase
    end
  end

  always_ff @(posedge system_clk) begin
    if (wr_push_ok) wr_mem[wr_wptr] <= cmd_data;
    if (rd_push_ok) rd_mem[rd_wptr] <= dma_rd_data;
  end

  always_ff @(posedge system_clk or posedge system_reset) begin
    if (system_reset) begin
      wr_wptr  <= '0;
      wr_rptr  <= '0;
      wr_count <= '0;
      rd_wptr  <= '0;
      rd_rptr  <= '0;
      rd_count <= '0;
    end else begin
      if (wr_push_ok) wr_wptr <= wr_wptr + AW'(1);
      if (wr_pop_ok)  wr_rptr <= wr_rptr + AW'(1);
      if (wr_push_ok && !wr_pop_ok)      wr_count <= wr_count + CW'(1);
      else if (wr_pop_ok && !wr_push_ok) wr_count <= wr_count - CW'(1);
      if (rd_push_ok) rd_wptr <= rd_wptr + AW'(1);
      if (rd_pop_ok)  rd_rptr <= rd_rptr + AW'(1);
      if (rd_push_ok && !rd_pop_ok)      rd_count <= rd_count + CW'(1);
      else if (rd_pop_ok && !rd_push_ok) rd_count <= rd_count - CW'(1);
    end
  end

  always_ff @(posedge system_clk or posedge system_reset) begin
    if (system_reset) begin
      state      <= S_IDLE;
      errors     <= '0;
      address_q  <= '0;
      byte_en_q  <= '1;
      burst_q    <= '0;
      dma_rnw    <= 1'b0;
      resp_valid <= 1'b0;
      resp_data  <= '0;
    end else begin
      resp_valid <= resp_hit;
      if (resp_hit) resp_data <= resp_next;

      errors <= ((accept && (cmd_opcode == 4'hF)) ? 3'b000 : errors) |
                {launch_req && launch_bad, rd_underflow, wr_overflow || rd_overflow};

      if (accept) begin
        case (cmd_opcode)
          4'h1:    address_q <= 32'(cmd_data);
          4'h2:    byte_en_q <= cmd_data[BEW-1:0];
          4'h3:    burst_q   <= cmd_data[BURST_WIDTH-1:0];
          default: ;
        endcase
      end

      case (state)
        S_IDLE: begin
          if (launch_req && !launch_bad) begin
            state   <= S_ISSUE;
            dma_rnw <= (cmd_opcode == 4'hC);
          end
        end
        S_ISSUE:     state <= S_WAIT_BUSY;
        S_WAIT_BUSY: if (dma_busy)  state <= S_WAIT_DONE;
        S_WAIT_DONE: if (!dma_busy) state <= S_IDLE;
        default:     state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_jtag_dma_cmd_engine.sv
// tb/tb_jtag_dma_cmd_engine.sv - randomized and directed checks against a queue-based reference model
module tb_jtag_dma_cmd_engine;

  localparam int DW    = 32;
  localparam int DEPTH = 4;
  localparam int BW    = 8;
  localparam int CW    = 3;

  logic          system_clk = 1'b0;
  logic          system_reset;
  logic          cmd_valid;
  logic          cmd_ready;
  logic [3:0]    cmd_opcode;
  logic [DW-1:0] cmd_data;
  logic          resp_valid;
  logic [DW-1:0] resp_data;
  logic          dma_start;
  logic          dma_rnw;
  logic [31:0]   dma_address;
  logic [DW/8-1:0] dma_byte_enable;
  logic [BW-1:0] dma_burst_size;
  logic          dma_busy;
  logic          dma_wr_pop;
  logic [DW-1:0] dma_wr_data;
  logic          dma_rd_push;
  logic [DW-1:0] dma_rd_data;

  jtag_dma_cmd_engine #(.DATA_WIDTH(DW), .BUF_DEPTH(DEPTH), .BURST_WIDTH(BW)) dut (
    .system_clk(system_clk), .system_reset(system_reset),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_opcode(cmd_opcode), .cmd_data(cmd_data),
    .resp_valid(resp_valid), .resp_data(resp_data),
    .dma_start(dma_start), .dma_rnw(dma_rnw), .dma_address(dma_address),
    .dma_byte_enable(dma_byte_enable), .dma_burst_size(dma_burst_size),
    .dma_busy(dma_busy), .dma_wr_pop(dma_wr_pop), .dma_wr_data(dma_wr_data),
    .dma_rd_push(dma_rd_push), .dma_rd_data(dma_rd_data)
  );

  always #5 system_clk = ~system_clk;

  int total = 0;
  int bad   = 0;

  // reference model; state numbering follows the listed order IDLE, ISSUE, WAIT_BUSY, WAIT_DONE
  int          m_state;
  logic [2:0]  m_err;
  logic [31:0] m_addr;
  logic [3:0]  m_be;
  logic [7:0]  m_burst;
  logic        m_rnw;
  logic        m_resp_v;
  logic [31:0] m_resp_d;
  logic [31:0] wq[$];
  logic [31:0] rq[$];

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic model_reset();
    m_state = 0; m_err = 0; m_addr = 0; m_be = 4'hF; m_burst = 0; m_rnw = 0;
    m_resp_v = 0; m_resp_d = 0;
    wq.delete(); rq.delete();
  endtask

  task automatic check_outputs();
    check("resp_valid", resp_valid, m_resp_v);
    check("resp_data", resp_data, m_resp_d);
    check("cmd_ready", cmd_ready, m_state == 0);
    check("dma_start", dma_start, m_state == 1);
    if (m_state == 1) check("dma_rnw", dma_rnw, m_rnw);
    check("dma_address", dma_address, m_addr);
    check("byte_enable", dma_byte_enable, m_be);
    check("burst_size", dma_burst_size, m_burst);
    if (wq.size() > 0) check("wr_data", dma_wr_data, wq[0]);
  endtask

  task automatic step(input bit cv, input logic [3:0] op, input logic [31:0] d,
                      input bit wpop, input bit rpush, input logic [31:0] rdat, input bit busy);
    bit acc;
    int wn, rn;
    logic [2:0] new_err;
    cmd_valid = cv; cmd_opcode = op; cmd_data = d;
    dma_wr_pop = wpop; dma_rd_push = rpush; dma_rd_data = rdat; dma_busy = busy;

    acc = cv && (m_state == 0);
    wn = wq.size(); rn = rq.size();
    new_err = 0;
    m_resp_v = 0;
    if (acc) begin
      case (op)
        4'h0: begin m_resp_v = 1; m_resp_d = (32'(m_err) << (2*CW+2)) | (wn << (CW+2)) | (rn << 2) | m_state; end
        4'h1: m_addr = d;
        4'h2: m_be = d[3:0];
        4'h3: m_burst = d[7:0];
        4'h4: begin m_resp_v = 1; m_resp_d = m_addr; end
        4'h5: begin m_resp_v = 1; m_resp_d = 32'(m_be); end
        4'h6: begin m_resp_v = 1; m_resp_d = 32'(m_burst); end
        default: ;
      endcase
    end
    // write FIFO: command pushes, DMA pops
    if (!(acc && op == 4'h8 && wpop && wn == 0)) begin
      if (wpop && wn > 0) void'(wq.pop_front());
      if (acc && op == 4'h8) begin
        if (wn < DEPTH || wpop) wq.push_back(d);
        else new_err[0] = 1;
      end
    end
    // read FIFO: DMA pushes, command pops
    if (acc && op == 4'h9) begin
      m_resp_v = 1;
      if (rn > 0) m_resp_d = rq.pop_front();
      else if (rpush) m_resp_d = rdat;
      else begin m_resp_d = 0; new_err[1] = 1; end
    end
    if (rpush && !(acc && op == 4'h9 && rn == 0)) begin
      if (rn < DEPTH || (acc && op == 4'h9)) rq.push_back(rdat);
      else new_err[0] = 1;
    end
    case (m_state)
      0: if (acc && (op == 4'hA || op == 4'hC)) begin
           if (busy || (op == 4'hA && wn < int'(m_burst) + 1)) new_err[2] = 1;
           else begin m_state = 1; m_rnw = (op == 4'hC); end
         end
      1: m_state = 2;
      2: if (busy) m_state = 3;
      3: if (!busy) m_state = 0;
      default: m_state = 0;
    endcase
    if (acc && op == 4'hF) m_err = 0;
    m_err = m_err | new_err;

    @(posedge system_clk);
    #1;
    check_outputs();
  endtask

  task automatic cmd(input logic [3:0] op, input logic [31:0] d);
    step(1, op, d, 0, 0, 0, 0);
  endtask

  initial begin
    system_reset = 1;
    cmd_valid = 0; cmd_opcode = 0; cmd_data = 0;
    dma_busy = 0; dma_wr_pop = 0; dma_rd_push = 0; dma_rd_data = 0;
    model_reset();
    repeat (2) @(posedge system_clk);
    #1;
    check("rst_cmd_ready", cmd_ready, 1);
    check("rst_resp_valid", resp_valid, 0);
    check("rst_resp_data", resp_data, 0);
    check("rst_dma_start", dma_start, 0);
    check("rst_address", dma_address, 0);
    check("rst_byte_en", dma_byte_enable, 4'hF);
    check("rst_burst", dma_burst_size, 0);
    system_reset = 0;

    // register write/readback
    cmd(4'h1, 32'h55555555);
    cmd(4'h4, 0);
    check("single_resp_pulse", resp_valid, 1);
    step(0, 4'h4, 0, 0, 0, 0, 0);
    check("resp_pulse_ends", resp_valid, 0);
    cmd(4'h2, 32'h0000000A);
    cmd(4'h5, 0);
    cmd(4'h6, 0);

    // write burst of two words
    cmd(4'h3, 1);
    cmd(4'h8, 32'h00ABCDEF);
    cmd(4'h8, 32'h01ABCDEF);
    cmd(4'hA, 0);
    check("wr_launch_start", dma_start, 1);
    step(0, 0, 0, 0, 0, 0, 0);
    step(0, 0, 0, 0, 0, 0, 1);
    check("wr_head0", dma_wr_data, 32'h00ABCDEF);
    step(0, 0, 0, 1, 0, 0, 1);
    check("wr_head1", dma_wr_data, 32'h01ABCDEF);
    step(0, 0, 0, 1, 0, 0, 1);
    step(0, 0, 0, 0, 0, 0, 0);
    cmd(4'h0, 0);

    // launch rejected while busy
    step(1, 4'hA, 0, 0, 0, 0, 1);
    check("busy_no_start", dma_start, 0);
    cmd(4'h0, 0);
    check("err2_set", resp_data[10], 1);
    cmd(4'hF, 0);
    cmd(4'h0, 0);

    // overflow and underflow
    for (int i = 0; i <= DEPTH; i++) cmd(4'h8, 32'h100 + i);
    cmd(4'h0, 0);
    check("wr_count_full", resp_data[7:5], DEPTH);
    check("err0_set", resp_data[8], 1);
    cmd(4'h9, 0);
    cmd(4'h0, 0);
    check("err1_set", resp_data[9], 1);
    cmd(4'hF, 0);

    // read burst of four words
    cmd(4'h3, 3);
    cmd(4'hC, 0);
    step(0, 0, 0, 0, 0, 0, 0);
    for (int i = 0; i < 4; i++) step(0, 0, 0, 0, 1, 32'hD000 + i, 1);
    step(0, 0, 0, 0, 0, 0, 0);
    cmd(4'h0, 0);
    check("rd_idle_state", resp_data[1:0], 0);
    for (int i = 0; i < 4; i++) begin
      cmd(4'h9, 0);
      check("rd_order", resp_data, 32'hD000 + i);
    end

    // randomized traffic
    for (int i = 0; i < 1500; i++) begin
      logic [3:0]  op;
      logic [31:0] d;
      op = 4'($urandom_range(0, 15));
      d  = $urandom;
      if (op == 4'h3) d = $urandom_range(0, 4);
      step($urandom_range(0, 2) != 0, op, d, $urandom_range(0, 2) == 0,
           $urandom_range(0, 2) == 0, $urandom, $urandom_range(0, 1) == 1);
    end

    // reset in the middle of a burst
    for (int i = 0; i < 6; i++) step(0, 0, 0, 0, 0, 0, 0);
    cmd(4'h1, 32'hCAFE0000);
    cmd(4'h4, 0);
    cmd(4'hC, 0);
    step(0, 0, 0, 0, 0, 0, 0);
    step(0, 0, 0, 0, 0, 0, 1);
    check("in_wait_done", cmd_ready, 0);
    #2;
    system_reset = 1;
    #1;
    model_reset();
    check_outputs();
    step(0, 0, 0, 0, 0, 0, 1);
    #2;
    system_reset = 0;
    step(0, 0, 0, 0, 0, 0, 1);
    step(0, 0, 0, 0, 0, 0, 0);
    cmd(4'h0, 0);
    check("post_rst_status", resp_data, 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
